// File: rtl/line_drawer_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_drawer_core_if                                               |
// | Brief  : line command channel plus pixel output channel of the line engine |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface line_drawer_core_if #(
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int COLOUR_W = 3
);
   logic                start;
   logic [X_W-1:0]      x0;
   logic [X_W-1:0]      x1;
   logic [Y_W-1:0]      y0;
   logic [Y_W-1:0]      y1;
   logic [COLOUR_W-1:0] colour;
   logic                ready;
   logic                plot;
   logic                plot_ready;
   logic [X_W-1:0]      x_out;
   logic [Y_W-1:0]      y_out;
   logic [COLOUR_W-1:0] colour_out;
   logic                done;

   modport master (
      output start, x0, x1, y0, y1, colour, plot_ready,
      input  ready, plot, x_out, y_out, colour_out, done
   );

   modport slave (
      input  start, x0, x1, y0, y1, colour, plot_ready,
      output ready, plot, x_out, y_out, colour_out, done
   );
endinterface
`default_nettype wire

// File: rtl/line_drawer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_drawer_core                                                  |
// | Brief  : Bresenham line engine, all octants, one pixel per accepted cycle. |
// |          Optional screen clipping enabled by defining LDA_CLIP_EN.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module line_drawer_core #(
   parameter int          X_W      = 9,
   parameter int          Y_W      = 8,
   parameter int          COLOUR_W = 3,
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 240
) (
   input wire           clk,
   input wire           reset,
   line_drawer_core_if.slave bus
);
   localparam int c_cw = (X_W > Y_W) ? X_W : Y_W;
   localparam int c_ew = c_cw + 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_INIT  = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state, w_state_nx;
   logic [c_cw-1:0]      r_x0, r_y0, r_x1, r_y1;
   logic [c_cw-1:0]      r_dx, r_dy, r_x, r_y;
   logic [COLOUR_W-1:0]  r_colour, r_colour_out;
   logic signed [c_ew-1:0] r_err;
   logic                 r_steep, r_ystep_neg, r_valid, r_last;
   logic [X_W-1:0]       r_x_out;
   logic [Y_W-1:0]       r_y_out;

   logic [c_cw-1:0]      w_adx, w_ady, w_a0, w_b0, w_a1, w_b1, w_px, w_py, w_y_nx;
   logic signed [c_ew-1:0] w_err_acc, w_err_nx;
   logic                 w_steep, w_clip, w_xfer, w_load;

   // Magnitudes serve SETUP on raw endpoints and INIT on the reordered ones.
   always_comb begin
      w_adx   = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
      w_ady   = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
      w_steep = w_ady > w_adx;
      w_a0    = w_steep ? r_y0 : r_x0;
      w_b0    = w_steep ? r_x0 : r_y0;
      w_a1    = w_steep ? r_y1 : r_x1;
      w_b1    = w_steep ? r_x1 : r_y1;
   end

   always_comb begin
      w_err_acc = r_err + $signed({2'b00, r_dy});
      w_err_nx  = w_err_acc;
      w_y_nx    = r_y;
      if (!w_err_acc[c_ew-1] && (w_err_acc != '0)) begin
         w_err_nx = w_err_acc - $signed({2'b00, r_dx});
         w_y_nx   = r_ystep_neg ? (r_y - 1'b1) : (r_y + 1'b1);
      end
      w_px = r_steep ? r_y : r_x;
      w_py = r_steep ? r_x : r_y;
   end

`ifdef LDA_CLIP_EN
   assign w_clip = ({{(32-X_W){1'b0}}, r_x_out} >= SCREEN_W) ||
                   ({{(32-Y_W){1'b0}}, r_y_out} >= SCREEN_H);
`else
   localparam int unsigned c_unused_screen = SCREEN_W + SCREEN_H;
   assign w_clip = 1'b0;
`endif

   // Output slot holds one pixel; a clipped pixel leaves without waiting on the framebuffer.
   assign w_xfer = r_valid && (bus.plot_ready || w_clip);
   assign w_load = !r_valid || w_xfer;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nx = S_SETUP;
         S_SETUP: w_state_nx = S_INIT;
         S_INIT:  w_state_nx = S_DRAW;
         S_DRAW:  if (w_xfer && r_last) w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0;
         r_dx <= '0; r_dy <= '0; r_x  <= '0; r_y  <= '0;
         r_err <= '0; r_colour <= '0; r_colour_out <= '0;
         r_steep <= 1'b0; r_ystep_neg <= 1'b0; r_valid <= 1'b0; r_last <= 1'b0;
         r_x_out <= '0; r_y_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_x0     <= c_cw'(bus.x0);
               r_y0     <= c_cw'(bus.y0);
               r_x1     <= c_cw'(bus.x1);
               r_y1     <= c_cw'(bus.y1);
               r_colour <= bus.colour;
            end
            S_SETUP: begin
               r_steep <= w_steep;
               if (w_a0 > w_a1) begin
                  r_x0 <= w_a1; r_y0 <= w_b1; r_x1 <= w_a0; r_y1 <= w_b0;
               end else begin
                  r_x0 <= w_a0; r_y0 <= w_b0; r_x1 <= w_a1; r_y1 <= w_b1;
               end
            end
            S_INIT: begin
               r_dx        <= w_adx;
               r_dy        <= w_ady;
               r_err       <= -$signed({2'b00, w_adx >> 1});
               r_ystep_neg <= !(r_y0 < r_y1);
               r_x         <= r_x0;
               r_y         <= r_y0;
               r_valid     <= 1'b0;
               r_last      <= 1'b0;
            end
            S_DRAW: begin
               if (w_xfer && r_last) begin
                  r_valid <= 1'b0;
               end else if (w_load) begin
                  r_valid      <= 1'b1;
                  r_x_out      <= w_px[X_W-1:0];
                  r_y_out      <= w_py[Y_W-1:0];
                  r_colour_out <= r_colour;
                  r_last       <= (r_x == r_x1);
                  r_x          <= r_x + 1'b1;
                  r_y          <= w_y_nx;
                  r_err        <= w_err_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready      = (r_state == S_IDLE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.plot       = r_valid && !w_clip;
   assign bus.x_out      = r_x_out;
   assign bus.y_out      = r_y_out;
   assign bus.colour_out = r_colour_out;
endmodule
`default_nettype wire

// File: tb/tb_line_drawer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_line_drawer_core                                               |
// | Brief  : directed line vectors against hand-derived pixel sequences        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_line_drawer_core;
   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COLOUR_W = 3;
`ifdef LDA_CLIP_EN
   localparam int unsigned c_screen_w = 160;
`else
   localparam int unsigned c_screen_w = 320;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   line_drawer_core_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

   line_drawer_core #(
      .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W),
      .SCREEN_W(c_screen_w), .SCREEN_H(240)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int exp_x[$];
   int exp_y[$];
   int exp_col;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after start was sampled.
   task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                             input int col);
      check_val("ready_before_start", int'(bus.ready), 1);
      bus.x0     = X_W'(ax0);
      bus.y0     = Y_W'(ay0);
      bus.x1     = X_W'(ax1);
      bus.y1     = Y_W'(ay1);
      bus.colour = COLOUR_W'(col);
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      check_val("busy_after_start", int'(bus.ready), 0);
   endtask

   task automatic collect(input int stall_idx, input int stall_len, input int done_lat,
                          input bit poke_done);
      int cyc = 0, npix = 0, first = -1, done_cnt = 0, done_cyc = -1, stalled = 0, held = 0;
      while (cyc < 100 && done_cnt == 0) begin
         @(negedge clk);
         cyc++;
         bus.plot_ready = 1'b1;
         if (bus.plot) begin
            if (first < 0) first = cyc;
            if (npix < exp_x.size()) begin
               check_val("pix_x", int'(bus.x_out), exp_x[npix]);
               check_val("pix_y", int'(bus.y_out), exp_y[npix]);
               check_val("pix_colour", int'(bus.colour_out), exp_col);
            end else begin
               check_val("extra_pixel", int'(bus.plot), 0);
            end
            if (npix == stall_idx) held++;
            if (npix == stall_idx && stalled < stall_len) begin
               bus.plot_ready = 1'b0;
               stalled++;
            end else begin
               npix++;
            end
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (poke_done) bus.start = 1'b1;
         end
      end
      check_val("first_latency", first, 3);
      check_val("pixel_count", npix, exp_x.size());
      check_val("done_pulses", done_cnt, 1);
      check_val("done_latency", done_cyc - first, done_lat);
      if (stall_idx >= 0) check_val("stall_hold", held, stall_len + 1);
      @(negedge clk);
      bus.start = 1'b0;
      check_val("done_one_cycle", int'(bus.done), 0);
      check_val("ready_after_done", int'(bus.ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  dcnt;
      bit  found;
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.x0         = '0;
      bus.y0         = '0;
      bus.x1         = '0;
      bus.y1         = '0;
      bus.colour     = '0;
      bus.plot_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_ready", int'(bus.ready), 1);
      check_val("rst_plot", int'(bus.plot), 0);
      check_val("rst_done", int'(bus.done), 0);
      check_val("rst_x", int'(bus.x_out), 0);
      check_val("rst_y", int'(bus.y_out), 0);
      check_val("rst_colour", int'(bus.colour_out), 0);
      reset = 1'b0;
      @(negedge clk);

      // Horizontal line, then back-to-back lines from the first IDLE cycle
      exp_x = '{0, 1, 2, 3, 4}; exp_y = '{0, 0, 0, 0, 0}; exp_col = 1;
      start_line(0, 0, 4, 0, 1);
      collect(-1, 0, 5, 1'b0);

      exp_x = '{2, 2, 2, 2, 2}; exp_y = '{3, 4, 5, 6, 7}; exp_col = 2;
      start_line(2, 7, 2, 3, 2);
      collect(-1, 0, 5, 1'b0);

      exp_x = '{0, 1, 2, 3}; exp_y = '{0, 1, 2, 3}; exp_col = 5;
      start_line(0, 0, 3, 3, 5);
      collect(-1, 0, 4, 1'b0);

      exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 1, 1}; exp_col = 3;
      start_line(0, 0, 3, 1, 3);
      collect(1, 2, 6, 1'b0);

      exp_x = '{1, 2, 3, 4, 5, 6}; exp_y = '{3, 3, 2, 2, 1, 1}; exp_col = 6;
      start_line(6, 1, 1, 3, 6);
      collect(-1, 0, 6, 1'b0);

      // Single pixel; a start raised during the done cycle must be ignored
      exp_x = '{10}; exp_y = '{10}; exp_col = 7;
      start_line(10, 10, 10, 10, 7);
      collect(-1, 0, 1, 1'b1);

      // Reset while the third pixel is on the output
      start_line(0, 0, 9, 0, 4);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.plot && bus.x_out == X_W'(2)) found = 1'b1;
      end
      check_val("reset_target_reached", int'(found), 1);
      reset = 1'b1;
      @(negedge clk);
      check_val("abort_plot", int'(bus.plot), 0);
      check_val("abort_ready", int'(bus.ready), 1);
      check_val("abort_done", int'(bus.done), 0);
      reset = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done || bus.plot) dcnt++;
      end
      check_val("no_activity_after_abort", dcnt, 0);

`ifdef LDA_CLIP_EN
      exp_x = '{158, 159}; exp_y = '{5, 5}; exp_col = 1;
      start_line(158, 5, 162, 5, 1);
      collect(-1, 0, 5, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
